sobel_window_gen: RTL and testbench

- Upstream neighbour of the Sobel gradient stage. Accepts a raster-order 8-bit grayscale pixel stream, one pixel per accepted cycle.
- Buffers two full image lines and forms a 3x3 neighbourhood window that is presented on d0_o..d8_o with a one-cycle strobe.
- win_valid_o connects directly to the gradient stage's done_i; d0_o..d8_o connect to d0_i..d8_i.
- Only interior windows are produced, so one frame yields (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows.

---
 rtl/sobel_window_gen.sv | 157 +++++++++++++++
 tb/tb_sobel_window_gen.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_gen.sv
// Forms 3x3 neighbourhood windows from a raster pixel stream via two line buffers.
// Define SOBEL_WIN_FRAME_ERR_EN to add the sticky framing error flag err_o.
module sobel_window_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sof_i,
    input  logic [DATA_W-1:0] pix_i,
    input  logic              pix_valid_i,
    output logic [DATA_W-1:0] d0_o,
    output logic [DATA_W-1:0] d1_o,
    output logic [DATA_W-1:0] d2_o,
    output logic [DATA_W-1:0] d3_o,
    output logic [DATA_W-1:0] d4_o,
    output logic [DATA_W-1:0] d5_o,
    output logic [DATA_W-1:0] d6_o,
    output logic [DATA_W-1:0] d7_o,
    output logic [DATA_W-1:0] d8_o,
    output logic              win_valid_o,
    output logic              frame_done_o,
    output logic              busy_o
`ifdef SOBEL_WIN_FRAME_ERR_EN
    ,
    output logic              err_o
`endif
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_e;

    state_e            state_q;
    logic [CW-1:0]     col_q;
    logic [RW-1:0]     row_q;
    logic [CW-1:0]     col_cur;
    logic [RW-1:0]     row_cur;
    logic [DATA_W-1:0] lb0_q [IMG_WIDTH];
    logic [DATA_W-1:0] lb1_q [IMG_WIDTH];
    logic [DATA_W-1:0] win_q [9];
    logic              win_valid_q;
    logic              frame_done_q;
    logic              busy_q;
    logic              restart;
    logic              accept;
    logic              col_last;
    logic              last_pix;
    logic [DATA_W-1:0] lb0_rd;
    logic [DATA_W-1:0] lb1_rd;

    // A sof-qualified pixel restarts the counters, so it is always pixel (0,0).
    always_comb begin
        restart  = pix_valid_i & sof_i & (state_q != DONE);
        accept   = pix_valid_i & ((state_q == ACTIVE) | restart);
        col_cur  = restart ? '0 : col_q;
        row_cur  = restart ? '0 : row_q;
        col_last = (col_cur == CW'(IMG_WIDTH - 1));
        last_pix = col_last & (row_cur == RW'(IMG_HEIGHT - 1));
    end

    assign lb0_rd = lb0_q[col_cur];
    assign lb1_rd = lb1_q[col_cur];

    always_ff @(posedge clk) begin
        if (accept) begin
            lb0_q[col_cur] <= lb1_rd;
            lb1_q[col_cur] <= pix_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            for (int i = 0; i < 9; i++) win_q[i] <= '0;
        end else begin
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            if (accept) begin
                win_q[0]    <= win_q[1];
                win_q[1]    <= win_q[2];
                win_q[2]    <= lb0_rd;
                win_q[3]    <= win_q[4];
                win_q[4]    <= win_q[5];
                win_q[5]    <= lb1_rd;
                win_q[6]    <= win_q[7];
                win_q[7]    <= win_q[8];
                win_q[8]    <= pix_i;
                win_valid_q <= (col_cur >= CW'(2)) & (row_cur >= RW'(2));
                if (col_last) begin
                    col_q <= '0;
                    row_q <= last_pix ? '0 : row_cur + 1'b1;
                end else begin
                    col_q <= col_cur + 1'b1;
                    row_q <= row_cur;
                end
            end
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= ACTIVE;
                        busy_q  <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (accept && last_pix) begin
                        state_q      <= DONE;
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                    end
                end
                DONE: state_q <= IDLE;
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign d0_o         = win_q[0];
    assign d1_o         = win_q[1];
    assign d2_o         = win_q[2];
    assign d3_o         = win_q[3];
    assign d4_o         = win_q[4];
    assign d5_o         = win_q[5];
    assign d6_o         = win_q[6];
    assign d7_o         = win_q[7];
    assign d8_o         = win_q[8];
    assign win_valid_o  = win_valid_q;
    assign frame_done_o = frame_done_q;
    assign busy_o       = busy_q;

`ifdef SOBEL_WIN_FRAME_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (pix_valid_i &&
                     (((state_q == IDLE) && !sof_i) ||
                      (state_q == DONE) ||
                      ((state_q == ACTIVE) && sof_i))) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen: a 4x4 and a 5x3 instance checked cycle by cycle
// against an image-array reference model, plus directed frame tables.
module tb_sobel_window_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sof = 1'b0;
    logic       pv  = 1'b0;
    logic [7:0] pix = 8'd0;

    always #5 clk = ~clk;

    logic [7:0] da [9];
    logic [7:0] db [9];
    logic va, vb, fda, fdb, ba, bb;
    logic erra, errb;

    bit          sel;
    logic [71:0] aw;
    logic        a_v, a_fd, a_busy, a_err;

    sobel_window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .DATA_W(8)) u_a (
        .clk(clk), .rst(rst), .sof_i(sof), .pix_i(pix), .pix_valid_i(pv),
        .d0_o(da[0]), .d1_o(da[1]), .d2_o(da[2]), .d3_o(da[3]), .d4_o(da[4]),
        .d5_o(da[5]), .d6_o(da[6]), .d7_o(da[7]), .d8_o(da[8]),
        .win_valid_o(va), .frame_done_o(fda), .busy_o(ba)
`ifdef SOBEL_WIN_FRAME_ERR_EN
        , .err_o(erra)
`endif
    );

    sobel_window_gen #(.IMG_WIDTH(5), .IMG_HEIGHT(3), .DATA_W(8)) u_b (
        .clk(clk), .rst(rst), .sof_i(sof), .pix_i(pix), .pix_valid_i(pv),
        .d0_o(db[0]), .d1_o(db[1]), .d2_o(db[2]), .d3_o(db[3]), .d4_o(db[4]),
        .d5_o(db[5]), .d6_o(db[6]), .d7_o(db[7]), .d8_o(db[8]),
        .win_valid_o(vb), .frame_done_o(fdb), .busy_o(bb)
`ifdef SOBEL_WIN_FRAME_ERR_EN
        , .err_o(errb)
`endif
    );

`ifndef SOBEL_WIN_FRAME_ERR_EN
    assign erra = 1'b0;
    assign errb = 1'b0;
`endif

    always_comb begin
        aw = '0;
        for (int i = 0; i < 9; i++) aw[71-8*i -: 8] = sel ? db[i] : da[i];
        a_v    = sel ? vb : va;
        a_fd   = sel ? fdb : fda;
        a_busy = sel ? bb : ba;
        a_err  = sel ? errb : erra;
    end

    // Reference model: image array plus frame position, updated per pixel.
    int          m_state;
    int          m_r, m_c;
    logic [7:0]  img [8][8];
    logic        m_err;
    logic        e_v, e_fd, e_busy;
    logic [71:0] e_win;

    int          nchk = 0;
    int          nerr = 0;
    logic [71:0] cap [$];
    int          nfd;
    bit          ldone;

    function automatic void cmp(string name, logic [71:0] act, logic [71:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void check();
        cmp("win_valid", 72'(a_v), 72'(e_v));
        cmp("frame_done", 72'(a_fd), 72'(e_fd));
        cmp("busy", 72'(a_busy), 72'(e_busy));
        if (e_v) cmp("window", aw, e_win);
`ifdef SOBEL_WIN_FRAME_ERR_EN
        cmp("err", 72'(a_err), 72'(m_err));
`endif
        if (a_v) cap.push_back(aw);
        if (a_fd) begin
            nfd++;
            if (a_v) ldone = 1'b1;
        end
    endfunction

    task automatic step(input bit s, input bit v, input logic [7:0] p);
        int w, h, nxt;
        bit acc;
        check();
        sof = s;
        pv  = v;
        pix = p;
        w = sel ? 5 : 4;
        h = sel ? 3 : 4;
        acc = v && (m_state == 1 || (m_state == 0 && s));
        if (v && ((m_state == 0 && !s) || m_state == 2 || (m_state == 1 && s)))
            m_err = 1'b1;
        e_v = 1'b0;
        nxt = (m_state == 2) ? 0 : m_state;
        if (acc) begin
            if (s) begin
                m_r = 0;
                m_c = 0;
            end
            img[m_r][m_c] = p;
            if (m_r >= 2 && m_c >= 2) begin
                e_v = 1'b1;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        e_win[71-8*(3*i+j) -: 8] = img[m_r-2+i][m_c-2+j];
            end
            nxt = 1;
            if (m_r == h - 1 && m_c == w - 1) begin
                nxt = 2;
                m_r = 0;
                m_c = 0;
            end else if (m_c == w - 1) begin
                m_c = 0;
                m_r++;
            end else begin
                m_c++;
            end
        end
        m_state = nxt;
        e_fd    = (nxt == 2);
        e_busy  = (nxt == 1);
        @(negedge clk);
    endtask

    task automatic do_reset();
        check();
        rst = 1'b1;
        sof = 1'b0;
        pv  = 1'b0;
        @(negedge clk);
        cmp("rst_valid", 72'(a_v), 72'd0);
        cmp("rst_done", 72'(a_fd), 72'd0);
        cmp("rst_busy", 72'(a_busy), 72'd0);
        cmp("rst_window", aw, 72'd0);
        rst     = 1'b0;
        m_state = 0;
        m_r     = 0;
        m_c     = 0;
        m_err   = 1'b0;
        e_v     = 1'b0;
        e_fd    = 1'b0;
        e_busy  = 1'b0;
        cap.delete();
        nfd   = 0;
        ldone = 1'b0;
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'd0);
    endtask

    typedef struct {
        logic [7:0]  base;
        bit          gaps;
        int          pre;
        int          n;
        logic [71:0] first;
        logic [71:0] last;
    } vec_t;

    vec_t vecs [3];

    initial begin
        vecs[0] = '{8'd0, 1'b0, 0, 4,
                    72'h00_01_02_04_05_06_08_09_0a, 72'h05_06_07_09_0a_0b_0d_0e_0f};
        vecs[1] = '{8'd0, 1'b1, 0, 4,
                    72'h00_01_02_04_05_06_08_09_0a, 72'h05_06_07_09_0a_0b_0d_0e_0f};
        vecs[2] = '{8'd100, 1'b0, 8, 4,
                    72'h64_65_66_68_69_6a_6c_6d_6e, 72'h69_6a_6b_6d_6e_6f_71_72_73};
        m_state = 0; m_r = 0; m_c = 0; m_err = 1'b0;
        e_v = 1'b0; e_fd = 1'b0; e_busy = 1'b0; e_win = '0;
        nfd = 0; ldone = 1'b0;
        sel = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 3; k++) begin
            sel = 1'b0;
            do_reset();
            if (vecs[k].pre > 0) begin
                for (int i = 0; i < vecs[k].pre; i++) step(i == 0, 1'b1, 8'(i));
                do_reset();
            end
            for (int i = 0; i < 16; i++) begin
                step(i == 0, 1'b1, vecs[k].base + 8'(i));
                if (vecs[k].gaps) step(1'b0, 1'b0, 8'd0);
            end
            flush(3);
            cmp("tbl_count", 72'(cap.size()), 72'(vecs[k].n));
            if (cap.size() > 0) begin
                cmp("tbl_first", cap[0], vecs[k].first);
                cmp("tbl_last", cap[cap.size()-1], vecs[k].last);
            end
            cmp("tbl_done_pulses", 72'(nfd), 72'd1);
            cmp("tbl_done_with_last", 72'(ldone), 72'd1);
        end

        // 5x3 frame: windows only in the last row, none across the wrap
        sel = 1'b1;
        do_reset();
        for (int i = 0; i < 15; i++) step(i == 0, 1'b1, 8'(i));
        flush(3);
        cmp("w5_count", 72'(cap.size()), 72'd3);
        for (int i = 0; i < cap.size() && i < 3; i++)
            cmp("w5_d8", 72'(cap[i][7:0]), 72'(12 + i));

        // Pixels in IDLE without sof are ignored
        sel = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'($urandom));
        flush(4);
        cmp("idle_count", 72'(cap.size()), 72'd0);
        cmp("idle_busy", 72'(a_busy), 72'd0);
`ifdef SOBEL_WIN_FRAME_ERR_EN
        cmp("idle_err", 72'(a_err), 72'd1);
`endif

        // Mid-frame abort at pixel 6 then a full frame
        do_reset();
        for (int i = 0; i < 6; i++) step(i == 0, 1'b1, 8'(i));
        for (int i = 0; i < 16; i++) step(i == 0, 1'b1, 8'(8'd50 + 8'(i)));
        flush(3);
        cmp("abort_count", 72'(cap.size()), 72'd4);
        if (cap.size() > 0)
            cmp("abort_first", cap[0], 72'h32_33_34_36_37_38_3a_3b_3c);
        cmp("abort_done_pulses", 72'(nfd), 72'd1);

        // Randomized traffic against the model on both geometries
        for (int d = 0; d < 2; d++) begin
            sel = (d == 0);
            do_reset();
            for (int n = 0; n < 2500; n++) begin
                bit v, s;
                v = ($urandom % 4) != 0;
                s = 1'b0;
                if (m_state == 0) s = ($urandom % 8) != 0;
                else if ($urandom % 60 == 0) s = 1'b1;
                if ($urandom % 400 == 0) do_reset();
                else step(s, v, 8'($urandom));
            end
            flush(2);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
